// File: rtl/doom_pkg.sv
// Shared game-state encodings and default game constants.
package doom_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PLAYING = 2'b01,
    HIT     = 2'b10,
    OVER    = 2'b11
  } game_state_e;

  localparam int unsigned DEF_MAX_HEALTH  = 5;
  localparam int unsigned DEF_FLASH_TICKS = 2;

endpackage

// File: rtl/bcd_score_counter.sv
// Two-digit BCD kill counter with synchronous clear and saturation at 99.
// One-cycle latency from clear_i/inc_i to score_o; clear_i has priority over inc_i.
module bcd_score_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_i,
  input  logic       inc_i,
  output logic [7:0] score_o
);

  logic [3:0] ones_q, ones_d;
  logic [3:0] tens_q, tens_d;
  logic       at_max;

  assign at_max = (tens_q == 4'd9) && (ones_q == 4'd9);

  always_comb begin
    ones_d = ones_q;
    tens_d = tens_q;
    if (clear_i) begin
      ones_d = 4'd0;
      tens_d = 4'd0;
    end else if (inc_i && !at_max) begin
      if (ones_q == 4'd9) begin
        ones_d = 4'd0;
        tens_d = tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ones_q <= 4'd0;
      tens_q <= 4'd0;
    end else begin
      ones_q <= ones_d;
      tens_q <= tens_d;
    end
  end

  assign score_o = {tens_q, ones_q};

endmodule

// File: rtl/game_status.sv
// Game state machine: start/restart, health with post-hit invulnerability, BCD score.
// Button and slow_clk are synchronised and edge-detected here; all outputs are registered.
module game_status
  import doom_pkg::*;
#(
  parameter int unsigned MAX_HEALTH  = DEF_MAX_HEALTH,
  parameter int unsigned FLASH_TICKS = DEF_FLASH_TICKS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       slow_clk,
  input  logic       start_btn,
  input  logic       enemy_attack,
  input  logic       enemy_kill,
  output logic       start,
  output logic [1:0] game_state,
  output logic [3:0] health,
  output logic [7:0] score_bcd,
  output logic       hit_flash
);

  localparam logic [3:0] HP_MAX  = 4'(MAX_HEALTH);
  localparam logic [7:0] FL_LAST = 8'(FLASH_TICKS - 1);

  logic btn_s1_q, btn_s2_q, btn_prev_q, btn_armed_q;
  logic [1:0] sync_vld_q;
  logic slow_s1_q, slow_s2_q, slow_prev_q;
  logic start_evt, tick;

  game_state_e state_q, state_d;
  logic [3:0]  health_q, health_d;
  logic [7:0]  flash_q, flash_d;
  logic        start_q, hit_flash_q;
  logic        score_clr, score_inc;

  // The button must be seen low once the synchroniser holds real data, so a
  // press held across reset release cannot masquerade as a fresh edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      btn_s1_q    <= 1'b0;
      btn_s2_q    <= 1'b0;
      btn_prev_q  <= 1'b0;
      btn_armed_q <= 1'b0;
      sync_vld_q  <= 2'b00;
      slow_s1_q   <= 1'b0;
      slow_s2_q   <= 1'b0;
      slow_prev_q <= 1'b0;
    end else begin
      btn_s1_q    <= start_btn;
      btn_s2_q    <= btn_s1_q;
      btn_prev_q  <= btn_s2_q;
      sync_vld_q  <= {sync_vld_q[0], 1'b1};
      if (sync_vld_q[1] && !btn_s2_q) begin
        btn_armed_q <= 1'b1;
      end
      slow_s1_q   <= slow_clk;
      slow_s2_q   <= slow_s1_q;
      slow_prev_q <= slow_s2_q;
    end
  end

  assign start_evt = btn_armed_q & btn_s2_q & ~btn_prev_q;
  assign tick      = slow_s2_q & ~slow_prev_q;

  always_comb begin
    state_d   = state_q;
    health_d  = health_q;
    flash_d   = flash_q;
    score_clr = 1'b0;
    score_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_evt) begin
          state_d   = PLAYING;
          health_d  = HP_MAX;
          score_clr = 1'b1;
        end
      end
      PLAYING: begin
        score_inc = enemy_kill;
        if (enemy_attack && (health_q != 4'd0)) begin
          health_d = health_q - 4'd1;
          state_d  = (health_q == 4'd1) ? OVER : HIT;
          flash_d  = 8'd0;
        end
      end
      HIT: begin
        // Attacks are ignored here: the player is invulnerable while flashing.
        score_inc = enemy_kill;
        if (tick) begin
          flash_d = flash_q + 8'd1;
          if (flash_q == FL_LAST) begin
            state_d = PLAYING;
          end
        end
      end
      OVER: begin
        if (start_evt) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      health_q    <= HP_MAX;
      flash_q     <= 8'd0;
      start_q     <= 1'b0;
      hit_flash_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      health_q    <= health_d;
      flash_q     <= flash_d;
      start_q     <= (state_d == PLAYING) || (state_d == HIT);
      hit_flash_q <= (state_d == HIT);
    end
  end

  bcd_score_counter u_score (
    .clk     (clk),
    .rst     (rst),
    .clear_i (score_clr),
    .inc_i   (score_inc),
    .score_o (score_bcd)
  );

  assign start      = start_q;
  assign game_state = state_q;
  assign health     = health_q;
  assign hit_flash  = hit_flash_q;

endmodule

// File: tb/tb_game_status.sv
// Scoreboard bench for game_status: a small game model pushes expected outputs, popped after each edge.
module tb_game_status;
  import doom_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       slow_clk = 1'b0;
  logic       start_btn = 1'b0;
  logic       enemy_attack = 1'b0;
  logic       enemy_kill = 1'b0;
  logic       start;
  logic [1:0] game_state;
  logic [3:0] health;
  logic [7:0] score_bcd;
  logic       hit_flash;

  always #5 clk = ~clk;

  game_status #(.MAX_HEALTH(5), .FLASH_TICKS(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .slow_clk     (slow_clk),
    .start_btn    (start_btn),
    .enemy_attack (enemy_attack),
    .enemy_kill   (enemy_kill),
    .start        (start),
    .game_state   (game_state),
    .health       (health),
    .score_bcd    (score_bcd),
    .hit_flash    (hit_flash)
  );

  typedef struct {
    string      tag;
    logic [1:0] st;
    logic [3:0] hp;
    logic [7:0] sc;
  } exp_t;

  exp_t       sbq[$];
  int         n_chk = 0;
  int         n_err = 0;
  logic [1:0] m_st;
  int         m_hp;
  int         m_sc;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic push(input string tag);
    sbq.push_back('{tag, m_st, 4'(m_hp), to_bcd(m_sc)});
  endtask

  task automatic pop_check();
    exp_t e;
    e = sbq.pop_front();
    chk({e.tag, ".state"}, 32'(game_state), 32'(e.st));
    chk({e.tag, ".health"}, 32'(health), 32'(e.hp));
    chk({e.tag, ".score"}, 32'(score_bcd), 32'(e.sc));
    chk({e.tag, ".start"}, 32'(start), 32'((e.st == PLAYING) || (e.st == HIT)));
    chk({e.tag, ".flash"}, 32'(hit_flash), 32'(e.st == HIT));
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic in_game();
    return (m_st == PLAYING) || (m_st == HIT);
  endfunction

  task automatic model_kill();
    if (in_game() && m_sc < 99) m_sc++;
  endtask

  task automatic model_attack();
    if (m_st == PLAYING) begin
      m_hp--;
      m_st = (m_hp == 0) ? OVER : HIT;
    end
  endtask

  // Start press: state must hold for two edges and change on the third.
  task automatic press_start(input int hold);
    push("btn_wait");
    start_btn = 1'b1;
    cyc(2);
    pop_check();
    if (m_st == IDLE) begin
      m_st = PLAYING; m_hp = 5; m_sc = 0;
    end else if (m_st == OVER) begin
      m_st = IDLE;
    end
    push("btn_evt");
    cyc(1);
    pop_check();
    cyc(hold - 3);
    start_btn = 1'b0;
    cyc(4);
  endtask

  task automatic pulse(input logic atk, input logic kill, input string tag);
    enemy_attack = atk;
    enemy_kill   = kill;
    if (kill) model_kill();
    if (atk) model_attack();
    push(tag);
    cyc(1);
    enemy_attack = 1'b0;
    enemy_kill   = 1'b0;
    pop_check();
  endtask

  task automatic slow_tick(input logic last, input string tag);
    if (last) m_st = PLAYING;
    push(tag);
    slow_clk = 1'b1;
    cyc(4);
    slow_clk = 1'b0;
    cyc(4);
    pop_check();
  endtask

  task automatic recover();
    slow_tick(1'b0, "tick1");
    slow_tick(1'b1, "tick2");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_st = IDLE; m_hp = 5; m_sc = 0;
    cyc(3);
    push("reset");
    cyc(1);
    pop_check();
    rst = 1'b1;
    cyc(4);

    press_start(10);
    pulse(1'b1, 1'b0, "atk1");
    chk("atk1_hp", 32'(health), 32'd4);
    pulse(1'b1, 1'b0, "atk_in_hit");
    chk("invuln_hp", 32'(health), 32'd4);
    recover();
    press_start(4);
    for (int i = 0; i < 4; i++) begin
      pulse(1'b1, 1'b0, "atk_loop");
      if (m_st == HIT) recover();
    end
    chk("over_state", 32'(game_state), 32'(OVER));
    pulse(1'b0, 1'b1, "kill_over");
    press_start(4);
    pulse(1'b0, 1'b1, "kill_idle");
    press_start(4);

    for (int k = 1; k <= 101; k++) begin
      pulse(1'b0, 1'b1, "kill");
      if (k == 9)   chk("score9",   32'(score_bcd), 32'h09);
      if (k == 10)  chk("score10",  32'(score_bcd), 32'h10);
      if (k == 100) chk("score100", 32'(score_bcd), 32'h99);
      if (k == 101) chk("score101", 32'(score_bcd), 32'h99);
    end

    for (int i = 0; i < 3; i++) begin
      pulse(1'b1, 1'b0, "atk_g1");
      if (i < 2) recover();
    end
    chk("hit_hp2", 32'(health), 32'd2);

    rst = 1'b0;
    start_btn = 1'b1;
    m_st = IDLE; m_hp = 5; m_sc = 0;
    push("mid_reset");
    cyc(1);
    pop_check();
    cyc(2);
    rst = 1'b1;
    push("held_btn");
    cyc(6);
    pop_check();
    start_btn = 1'b0;
    cyc(4);
    press_start(4);

    pulse(1'b1, 1'b0, "atk_g2");
    pulse(1'b0, 1'b1, "kill_hit");
    recover();
    for (int k = 0; k < 8; k++) pulse(1'b0, 1'b1, "kill_g2");
    for (int i = 0; i < 3; i++) begin
      pulse(1'b1, 1'b0, "atk_g2b");
      recover();
    end
    chk("pre_both_hp", 32'(health), 32'd1);
    pulse(1'b1, 1'b1, "atk_kill");
    chk("both_hp", 32'(health), 32'd0);
    chk("both_score", 32'(score_bcd), 32'h10);
    chk("both_state", 32'(game_state), 32'(OVER));
    press_start(4);

    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/game_status.md
GAME_STATUS -- requirements
Module: game_status

Interface
REQ-001 Parameter: MAX_HEALTH, default 5, starting and maximum player health (range 1-15).
REQ-002 Parameter: FLASH_TICKS, default 2, number of slow_clk rising edges spent in HIT.
REQ-003 Port: clk  input  1  system clock; the only clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset; synchronous and active-low.
REQ-005 Port: slow_clk  input  1  ~3 Hz level from the top divider; sampled as data, never used as a clock.
REQ-006 Port: start_btn  input  1  raw, asynchronous start/restart button.
REQ-007 Port: enemy_attack  input  1  one-cycle pulse; an enemy has hit the player.
REQ-008 Port: enemy_kill  input  1  one-cycle pulse; the player has killed an enemy.
REQ-009 Port: start  output  1  high while state is PLAYING or HIT; drives enemy_controller start.
REQ-010 Port: game_state  output  2  IDLE=00, PLAYING=01, HIT=10, OVER=11.
REQ-011 Port: health  output  4  remaining health, binary.
REQ-012 Port: score_bcd  output  8  kill count as two BCD digits: [7:4] tens, [3:0] ones.
REQ-013 Port: hit_flash  output  1  high exactly while the state is HIT.

Function
REQ-014 start_btn SHALL pass through a 2-flop synchronizer and then a rising-edge detector; the resulting start_evt is a one-cycle pulse.
REQ-015 slow_clk SHALL be edge-detected the same way to form tick, a one-cycle pulse on each rising edge.
REQ-016 In IDLE, start_evt SHALL move the state to PLAYING, load health with MAX_HEALTH and clear score_bcd to 00.
REQ-017 In PLAYING, enemy_attack SHALL decrement health by 1; if the result is 0 the next state is OVER, otherwise it is HIT.
REQ-018 In HIT, enemy_attack SHALL be ignored (invulnerability); the flash counter SHALL clear on entry and increment on each tick.
REQ-019 HIT SHALL return to PLAYING in the cycle after the FLASH_TICKS-th tick.
REQ-020 enemy_kill SHALL increment score_bcd in PLAYING and HIT only; it SHALL be ignored in IDLE and OVER.
REQ-021 BCD increment rule: ones 9 -> 0 with carry into tens; at 99 the score saturates and further kills leave it at 99.
REQ-022 enemy_attack and enemy_kill in the same cycle SHALL both take effect: the score increments and the health rule applies.
REQ-023 In OVER, health (0) and score_bcd SHALL hold; start_evt SHALL move the state to IDLE.
REQ-024 A new game starts only from IDLE, so two start presses are needed after game over.
REQ-025 start_evt in PLAYING or HIT SHALL be ignored.
REQ-026 All outputs SHALL be registered; an input pulse in cycle n is reflected on the outputs in cycle n+1.
REQ-027 Latency from a start_btn rising edge to the state change is 3 clk cycles (synchronizer, edge detect, state register).
REQ-028 health SHALL never underflow below 0 and never exceed MAX_HEALTH.

Reset
REQ-029 With rst low at a clk edge: game_state = IDLE, health = MAX_HEALTH, score_bcd = 00, start = 0, hit_flash = 0, flash counter = 0.
REQ-030 Reset SHALL also clear the synchronizer and edge-detect flops to 0.
REQ-031 Reset asserted mid-game SHALL abort immediately, with no OVER pass.
REQ-032 A button held high through reset release SHALL NOT generate start_evt until it is released and pressed again.

Structure
REQ-033 Shared package doom_pkg SHALL hold the state encodings (IDLE/PLAYING/HIT/OVER) and the default MAX_HEALTH and FLASH_TICKS constants.
REQ-034 One sub-module, bcd_score_counter (clear, inc, saturating two-digit BCD output), SHALL implement REQ-021.
REQ-035 Edge detection is inline logic, not a separate module.

Verification
REQ-036 Reset, then raise start_btn for 10 cycles -> game_state goes 00 -> 01 three cycles after the edge, start = 1, health = 5, score_bcd = 0x00.
REQ-037 While PLAYING, pulse enemy_attack -> health = 4, state HIT, hit_flash = 1.
REQ-038 Send a second attack during HIT -> health stays 4.
REQ-039 After 2 slow_clk rising edges in HIT -> state returns to PLAYING.
REQ-040 Apply 5 attacks, each separated by HIT recovery -> health 5 -> 0, state OVER, start = 0.
REQ-041 In OVER, pulse enemy_kill -> score_bcd is unchanged.
REQ-042 Apply 9 kills -> score_bcd = 0x09; the 10th kill -> 0x10; 100 kills total -> 0x99 and holds at 0x99 on the 101st.
REQ-043 Pulse attack and kill in the same cycle with health = 1 and score 0x09 -> health = 0, state OVER, score_bcd = 0x10.
REQ-044 Pull rst low during HIT with health 2 -> the next cycle shows IDLE, health = 5, score_bcd = 0x00, hit_flash = 0.
